// File: rtl/cr_kme_key_tlv_req_dup_pkg.sv
// Shared types for the key-request TLV duplicator.
//   tlvp_if_bus_t      : one TLV bus word as carried on the CCEIP/KME request streams
//   tlv_word_0_t       : layout of tdata on the first (sot) word of a frame
//   SOT_WAIT / FWD     : request FSM state encodings
//   dup_word()         : the word as driven downstream (tlast follows eot, ordern forced to 1)
package cr_kme_key_tlv_req_dup_pkg;

  localparam int unsigned TLVP_ORD_NUM_WIDTH = 13;

  typedef struct packed {
    logic                          insert;
    logic [TLVP_ORD_NUM_WIDTH-1:0] ordern;
    logic [7:0]                    typen;
    logic                          sot;
    logic                          eot;
    logic                          tlast;
    logic                          tid;
    logic [7:0]                    tstrb;
    logic [7:0]                    tuser;
    logic [63:0]                   tdata;
  } tlvp_if_bus_t;

  typedef struct packed {
    logic [31:0] resv0;
    logic [3:0]  tlv_frame_num;
    logic [3:0]  tlv_eng_id;
    logic [7:0]  tlv_seq_num;
    logic [7:0]  tlv_len;
    logic [1:0]  resv1;
    logic [5:0]  tlv_type;
  } tlv_word_0_t;

  localparam logic [0:0] SOT_WAIT = 1'b0;
  localparam logic [0:0] FWD      = 1'b1;

  function automatic tlvp_if_bus_t dup_word(input tlvp_if_bus_t w);
    tlvp_if_bus_t r;
    r        = w;
    r.tlast  = w.eot;
    r.ordern = TLVP_ORD_NUM_WIDTH'(1);
    return r;
  endfunction

  function automatic logic [3:0] eng_id_of(input logic [63:0] tdata);
    tlv_word_0_t w0;
    w0 = tlv_word_0_t'(tdata);
    return w0.tlv_eng_id;
  endfunction

endpackage

// File: rtl/cr_kme_fifo.sv
// Small synchronous skid FIFO.
//   in_valid/in_data   : write side; a write while full is dropped
//   in_stall           : full indication (suppressed by stall_override)
//   out_valid/out_data : head of FIFO, visible combinationally
//   out_ack            : pop the head this cycle
module cr_kme_fifo #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 in_stall,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  input  logic                 out_ack,
  input  logic                 stall_override
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 full, push, pop;

  assign full      = (cnt_q == FullCnt);
  assign push      = in_valid & ~full;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_ack & out_valid;
  assign out_data  = mem_q[rd_ptr_q];
  assign in_stall  = full & ~stall_override;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: rtl/cr_kme_key_tlv_req_dup.sv
// Key-request TLV duplicator: buffers CCEIP0 request words and forwards each one, in lockstep,
// to both the encrypt and validate request streams. Framing, engine id and frame length are
// checked; any violation raises a single-cycle error pulse.
//   cceip_ib_wr/tlv/full/afull : inbound request stream (afull tied low)
//   encrypt_ib_wr/tlv/full     : outbound copy to the encrypt pipeline
//   validate_ib_wr/tlv/full    : outbound copy to the validate pipeline
//   set_key_req_proto_err_int  : one-cycle protocol error pulse
module cr_kme_key_tlv_req_dup
  import cr_kme_key_tlv_req_dup_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WORDS  = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cceip_ib_wr,
  input  tlvp_if_bus_t cceip_ib_tlv,
  output logic         cceip_ib_full,
  output logic         cceip_ib_afull,
  output logic         encrypt_ib_wr,
  output tlvp_if_bus_t encrypt_ib_tlv,
  input  logic         encrypt_ib_full,
  output logic         validate_ib_wr,
  output tlvp_if_bus_t validate_ib_tlv,
  input  logic         validate_ib_full,
  output logic         set_key_req_proto_err_int
);

  // Wide enough to hold the MAX_WORDS+1 saturation value for any MAX_WORDS.
  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 2);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CntSat = CNT_W'(MAX_WORDS + 1);

  logic         fifo_out_valid, fifo_pop, go, fwd, err;
  tlvp_if_bus_t head;
  logic [0:0]   state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  cr_kme_fifo #(
    .DATA_SIZE  ($bits(tlvp_if_bus_t)),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (cceip_ib_wr),
    .in_data        (cceip_ib_tlv),
    .in_stall       (cceip_ib_full),
    .out_valid      (fifo_out_valid),
    .out_data       (head),
    .out_ack        (fifo_pop),
    .stall_override (1'b0)
  );

  // Both sides must be ready; a word is never written to one pipeline alone.
  assign go = fifo_out_valid & ~encrypt_ib_full & ~validate_ib_full;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    fwd        = 1'b0;
    fifo_pop   = 1'b0;
    err        = 1'b0;
    if (fifo_out_valid) begin
      case (state_q)
        SOT_WAIT: begin
          if (head.sot) begin
            if (go) begin
              fwd      = 1'b1;
              fifo_pop = 1'b1;
              err      = (eng_id_of(head.tdata) != 4'd0);
              if (head.eot) begin
                word_cnt_d = '0;
              end else begin
                state_d    = FWD;
                word_cnt_d = CNT_W'(1);
              end
            end
          end else begin
            // Stray word outside a frame: discard without waiting for downstream.
            fifo_pop = 1'b1;
            err      = 1'b1;
          end
        end
        FWD: begin
          if (go) begin
            fwd      = 1'b1;
            fifo_pop = 1'b1;
            // Flagging only the (MAX_WORDS+1)th word gives one length pulse per frame,
            // whether or not eot lands on that word.
            err      = head.sot | (word_cnt_q == CntMax);
            if (head.eot) begin
              state_d    = SOT_WAIT;
              word_cnt_d = '0;
            end else if (word_cnt_q != CntSat) begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = SOT_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SOT_WAIT;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign encrypt_ib_wr             = fwd;
  assign validate_ib_wr            = fwd;
  assign encrypt_ib_tlv            = fwd ? dup_word(head) : '0;
  assign validate_ib_tlv           = fwd ? dup_word(head) : '0;
  assign set_key_req_proto_err_int = err;
  assign cceip_ib_afull            = 1'b0;

endmodule

// File: tb/tb_cr_kme_key_tlv_req_dup.sv
module tb_cr_kme_key_tlv_req_dup;
  import cr_kme_key_tlv_req_dup_pkg::*;

  localparam int DEPTH = 2;
  localparam int MAXW  = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cceip_ib_wr;
  tlvp_if_bus_t cceip_ib_tlv;
  logic         cceip_ib_full, cceip_ib_afull;
  logic         encrypt_ib_wr, validate_ib_wr;
  tlvp_if_bus_t encrypt_ib_tlv, validate_ib_tlv;
  logic         encrypt_ib_full, validate_ib_full;
  logic         set_key_req_proto_err_int;

  cr_kme_key_tlv_req_dup #(
    .FIFO_DEPTH (DEPTH),
    .MAX_WORDS  (MAXW)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .cceip_ib_wr               (cceip_ib_wr),
    .cceip_ib_tlv              (cceip_ib_tlv),
    .cceip_ib_full             (cceip_ib_full),
    .cceip_ib_afull            (cceip_ib_afull),
    .encrypt_ib_wr             (encrypt_ib_wr),
    .encrypt_ib_tlv            (encrypt_ib_tlv),
    .encrypt_ib_full           (encrypt_ib_full),
    .validate_ib_wr            (validate_ib_wr),
    .validate_ib_tlv           (validate_ib_tlv),
    .validate_ib_full          (validate_ib_full),
    .set_key_req_proto_err_int (set_key_req_proto_err_int)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: words accepted but not yet consumed, plus frame position.
  tlvp_if_bus_t mq[$];
  bit m_in_frame = 0;
  int m_n = 0;

  // Observation statistics (cumulative; scenarios use deltas).
  int wr_cnt = 0, err_cnt = 0, err_at = 0, full_seen = 0, ord_bad = 0;
  bit last_tlast = 0;

  int cyc = 0, vfrom = 0, vto = -1;
  bit smode = 0;
  bit done = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    tlvp_if_bus_t hd, exp_tlv;
    bit e_fwd, e_pop, e_err, e_full, go;
    e_fwd = 0; e_pop = 0; e_err = 0; exp_tlv = '0;
    if (!rst_n) begin
      mq.delete();
      m_in_frame = 0;
      m_n = 0;
      chk("reset_ctrl", {123'd0, encrypt_ib_wr, validate_ib_wr, set_key_req_proto_err_int,
                         cceip_ib_full, cceip_ib_afull}, '0);
      chk("reset_data", encrypt_ib_tlv | validate_ib_tlv, '0);
      return;
    end
    e_full = (mq.size() >= DEPTH);
    if (mq.size() > 0) begin
      hd = mq[0];
      go = !encrypt_ib_full && !validate_ib_full;
      if (!m_in_frame) begin
        if (hd.sot) begin
          if (go) begin
            e_fwd = 1; e_pop = 1;
            e_err = (hd.tdata[27:24] != 4'd0);
            if (!hd.eot) begin m_in_frame = 1; m_n = 1; end
          end
        end else begin
          e_pop = 1; e_err = 1;
        end
      end else if (go) begin
        e_fwd = 1; e_pop = 1;
        m_n++;
        e_err = hd.sot || (m_n == MAXW + 1);
        if (hd.eot) m_in_frame = 0;
      end
      if (e_fwd) begin
        exp_tlv = hd;
        exp_tlv.tlast = hd.eot;
        exp_tlv.ordern = TLVP_ORD_NUM_WIDTH'(1);
      end
    end
    chk("enc_wr", encrypt_ib_wr, e_fwd);
    chk("val_wr", validate_ib_wr, e_fwd);
    chk("enc_tlv", encrypt_ib_tlv, exp_tlv);
    chk("val_tlv", validate_ib_tlv, exp_tlv);
    chk("err_pulse", set_key_req_proto_err_int, e_err);
    chk("ib_full", cceip_ib_full, e_full);
    chk("ib_afull", cceip_ib_afull, 1'b0);
    if (encrypt_ib_wr) begin
      wr_cnt++;
      last_tlast = encrypt_ib_tlv.tlast;
      if (encrypt_ib_tlv.ordern != TLVP_ORD_NUM_WIDTH'(1)) ord_bad++;
    end
    if (set_key_req_proto_err_int) begin err_cnt++; err_at = wr_cnt; end
    if (cceip_ib_full) full_seen++;
    if (e_pop) void'(mq.pop_front());
    if (cceip_ib_wr && !e_full) mq.push_back(cceip_ib_tlv);
  endtask

  function automatic tlvp_if_bus_t mk(input bit sot, input bit eot, input logic [3:0] eng);
    tlvp_if_bus_t w;
    w = '0;
    w.insert = 1'($urandom);
    w.ordern = TLVP_ORD_NUM_WIDTH'($urandom);
    w.typen  = 8'($urandom);
    w.tid    = 1'($urandom);
    w.tstrb  = 8'($urandom);
    w.tuser  = 8'($urandom);
    w.tdata  = {$urandom, $urandom};
    w.tdata[27:24] = eng;
    w.sot    = sot;
    w.eot    = eot;
    w.tlast  = 1'($urandom);
    return w;
  endfunction

  task automatic send_word(input tlvp_if_bus_t w, input bit honor);
    int t = 0;
    if (honor) begin
      while (cceip_ib_full && t < 200) begin
        cceip_ib_wr = 0;
        @(posedge clk); #1;
        t++;
      end
      chk("full_wait_timeout", t >= 200, 1'b0);
    end
    cceip_ib_wr  = 1;
    cceip_ib_tlv = w;
    @(posedge clk); #1;
    cceip_ib_wr  = 0;
  endtask

  task automatic send_frame(input int len, input logic [3:0] eng, input bit honor);
    for (int i = 0; i < len; i++)
      send_word(mk(i == 0, i == len - 1, (i == 0) ? eng : 4'($urandom)), honor);
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic main_seq();
    int b_wr, b_err, b_full;
    rst_n = 0; cceip_ib_wr = 0; cceip_ib_tlv = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enc_wr", encrypt_ib_wr, 1'b0);
    chk("rst_full", cceip_ib_full, 1'b0);
    rst_n = 1;
    @(posedge clk); #1;

    // 1: clean 4-word frame
    b_wr = wr_cnt; b_err = err_cnt;
    send_frame(4, 4'd0, 1);
    drain();
    chk("t1_writes", wr_cnt - b_wr, 4);
    chk("t1_errs", err_cnt - b_err, 0);
    chk("t1_tlast", last_tlast, 1'b1);
    chk("t1_ordern", ord_bad, 0);

    // 2: validate side stalled for four cycles mid-frame
    b_wr = wr_cnt; b_err = err_cnt; b_full = full_seen;
    vfrom = cyc + 2; vto = cyc + 5;
    send_frame(4, 4'd0, 1);
    drain();
    chk("t2_writes", wr_cnt - b_wr, 4);
    chk("t2_errs", err_cnt - b_err, 0);
    chk("t2_full_seen", (full_seen - b_full) > 0, 1'b1);

    // 3: stray word then a 2-word frame
    b_wr = wr_cnt; b_err = err_cnt;
    send_word(mk(0, 0, 4'd0), 1);
    send_frame(2, 4'd0, 1);
    drain();
    chk("t3_writes", wr_cnt - b_wr, 2);
    chk("t3_errs", err_cnt - b_err, 1);

    // 4: over-length frame
    b_wr = wr_cnt; b_err = err_cnt;
    send_frame(MAXW + 2, 4'd0, 1);
    drain();
    chk("t4_writes", wr_cnt - b_wr, MAXW + 2);
    chk("t4_errs", err_cnt - b_err, 1);
    chk("t4_err_word", err_at - b_wr, MAXW + 1);

    // 5: single-word frame with nonzero engine id, then a clean single word
    b_wr = wr_cnt; b_err = err_cnt;
    send_frame(1, 4'd3, 1);
    drain();
    chk("t5_writes", wr_cnt - b_wr, 1);
    chk("t5_errs", err_cnt - b_err, 1);
    send_frame(1, 4'd0, 1);
    drain();
    chk("t5_back_in_sot_wait", err_cnt - b_err, 1);

    // 6: reset at word 2 of a 5-word frame
    send_word(mk(1, 0, 4'd0), 1);
    send_word(mk(0, 0, 4'd0), 1);
    rst_n = 0;
    #1;
    chk("t6_rst_wr", {encrypt_ib_wr, validate_ib_wr}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    b_wr = wr_cnt; b_err = err_cnt;
    send_frame(3, 4'd0, 1);
    drain();
    chk("t6_writes", wr_cnt - b_wr, 3);
    chk("t6_errs", err_cnt - b_err, 0);

    // Random phase: random stalls, strays, bad engine ids, dropped writes.
    smode = 1;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 7) == 0) send_word(mk(0, $urandom_range(0, 1) == 1, 4'd0), 1);
      send_frame($urandom_range(1, 7), ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0,
                 $urandom_range(0, 3) != 0);
    end
    smode = 0;
    drain();
    done = 1;
  endtask

  initial begin
    encrypt_ib_full = 0;
    validate_ib_full = 0;
    rst_n = 0;
    cceip_ib_wr = 0;
    cceip_ib_tlv = '0;
    fork
      main_seq();
      forever begin
        @(negedge clk);
        compare_cycle();
      end
      forever begin
        @(posedge clk);
        #2;
        cyc++;
        encrypt_ib_full  = smode && ($urandom_range(0, 3) == 0);
        validate_ib_full = (smode && ($urandom_range(0, 3) == 0)) || (cyc >= vfrom && cyc <= vto);
      end
      begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
